// File: rtl/bnn_dense_seq.sv
// bnn_dense_seq: chunked binarized dense layer, XNOR-popcount per neuron against a threshold
module bnn_dense_seq #(
   parameter int N_IN = 50,
   parameter int N_OUT = 10,
   parameter int CHUNK = 10,
   localparam int CW = $clog2(N_IN + 1),
   localparam int AW = N_OUT > 1 ? $clog2(N_OUT) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IN-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N_OUT-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [N_IN-1:0]  cfg_w,
   input  logic [CW-1:0]    cfg_th
);
   localparam int NCH = (N_IN + CHUNK - 1) / CHUNK;
   localparam int PW = NCH * CHUNK;
   localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
   state_t state;
   logic [N_IN-1:0] w [N_OUT];
   logic [CW-1:0] th [N_OUT];
   logic [CW-1:0] acc [N_OUT];
   logic [CW-1:0] nacc [N_OUT];
   logic [PW-1:0] match [N_OUT];
   logic [CHUNK-1:0] seg [N_OUT];
   logic [N_IN-1:0] x;
   logic [IW-1:0] idx;
   assign in_ready = (state == IDLE) | (state == DONE & out_ready);
   // the mask zeroes the padding positions of the last partial chunk
   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         match[j] = ~(PW'(w[j]) ^ PW'(x)) & PW'({N_IN{1'b1}});
         seg[j] = CHUNK'(match[j] >> (32'(idx) * CHUNK));
         nacc[j] = acc[j] + CW'($countones(seg[j]));
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         for (int j = 0; j < N_OUT; j++) begin
            w[j] <= '0;
            th[j] <= '0;
            acc[j] <= '0;
         end
      end else begin
         if (state == IDLE && cfg_we && 32'(cfg_addr) < N_OUT) begin
            w[cfg_addr] <= cfg_w;
            th[cfg_addr] <= cfg_th;
         end
         if (state == ACC) begin
            for (int j = 0; j < N_OUT; j++) acc[j] <= nacc[j];
            idx <= idx + IW'(1);
            if (idx == IW'(NCH - 1)) begin
               for (int j = 0; j < N_OUT; j++) out_data[j] <= nacc[j] > th[j];
               out_valid <= 1'b1;
               state <= DONE;
            end
         end
         if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
         end
         if (in_valid && in_ready) begin
            x <= in_data;
            idx <= '0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
            state <= ACC;
         end
      end
   end
endmodule

// File: tb/tb_bnn_dense_seq.sv
// tb_bnn_dense_seq: queue-based reference model plus directed vectors for bnn_dense_seq
module tb_bnn_dense_seq;
   localparam int N_IN = 50, N_OUT = 10, NCH = 5;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [N_IN-1:0] in_data, cfg_w, b_in_data, b_cfg_w;
   logic in_valid, in_ready, out_valid, out_ready, cfg_we;
   logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cfg_we;
   logic [N_OUT-1:0] out_data, b_out_data;
   logic [3:0] cfg_addr, b_cfg_addr;
   logic [5:0] cfg_th, b_cfg_th;
   bnn_dense_seq dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w(cfg_w), .cfg_th(cfg_th));
   bnn_dense_seq #(.CHUNK(16)) dut2 (
      .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_w(b_cfg_w), .cfg_th(b_cfg_th));
   int n_cmp = 0, n_bad = 0;
   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask
   logic [N_IN-1:0] mw [N_OUT];
   logic [5:0] mth [N_OUT];
   typedef struct {logic [N_OUT-1:0] d; int rdy;} exp_t;
   exp_t q[$];
   int cyc = 0;
   function automatic logic [N_OUT-1:0] model(input logic [N_IN-1:0] xv);
      logic [N_OUT-1:0] r;
      for (int j = 0; j < N_OUT; j++) r[j] = $countones(~(mw[j] ^ xv)) > int'(mth[j]);
      return r;
   endfunction
   // a result is due NCH edges after acceptance and persists until consumed
   always @(posedge clk) begin : mon
      bit idle, take;
      exp_t e;
      if (rst) begin
         q.delete();
         for (int j = 0; j < N_OUT; j++) begin
            mw[j] = '0;
            mth[j] = '0;
         end
      end else begin
         idle = q.size() == 0;
         take = in_valid && (idle || (cyc >= q[0].rdy && out_ready));
         if (!idle && cyc >= q[0].rdy && out_ready) void'(q.pop_front());
         if (cfg_we && idle && cfg_addr < 4'd10) begin
            mw[cfg_addr] = cfg_w;
            mth[cfg_addr] = cfg_th;
         end
         if (take) begin
            e.d = model(in_data);
            e.rdy = cyc + 1 + NCH;
            q.push_back(e);
         end
      end
      cyc++;
   end
   always @(negedge clk) begin : cmp
      bit ev;
      if (!rst && cyc > 0) begin
         ev = q.size() > 0 && cyc >= q[0].rdy;
         check("out_valid", out_valid, ev);
         check("in_ready", in_ready, q.size() == 0 || (ev && out_ready));
         if (ev) check("out_data", out_data, q[0].d);
      end
   end
   task automatic cfg(input int a, input logic [N_IN-1:0] wv, input int t);
      cfg_we = 1'b1;
      cfg_addr = 4'(a);
      cfg_w = wv;
      cfg_th = 6'(t);
      @(posedge clk);
      #1 cfg_we = 1'b0;
   endtask
   task automatic send(input logic [N_IN-1:0] xv);
      int t = 0;
      bit ok;
      in_valid = 1'b1;
      in_data = xv;
      do begin
         @(posedge clk);
         ok = in_ready;
         t++;
      end while (!ok && t < 50);
      #1 in_valid = 1'b0;
      check("send_accept", ok, 1);
   endtask
   task automatic wait_lat(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!out_valid && n < 20);
   endtask
   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask
   function automatic logic [N_IN-1:0] rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[N_IN-1:0];
   endfunction
   initial begin
      int n, k, pulses, gap;
      logic [N_IN-1:0] xv, v [3];
      logic [N_OUT-1:0] e;
      bit a;
      {in_valid, out_ready, cfg_we, b_in_valid, b_out_ready, b_cfg_we} = '0;
      {in_data, cfg_w, b_in_data, b_cfg_w} = '0;
      {cfg_addr, b_cfg_addr, cfg_th, b_cfg_th} = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      for (int j = 0; j < N_OUT; j++) cfg(j, '1, 49);
      send('1);
      wait_lat(n);
      check("lat_th49", n, 5);
      check("ones_th49", out_data, 10'h3FF);
      consume();
      for (int j = 0; j < N_OUT; j++) cfg(j, '1, 50);
      send('1);
      wait_lat(n);
      check("ones_th50", out_data, 10'h000);
      consume();
      for (int j = 0; j < N_OUT; j++) cfg(j, '0, 24);
      send('0);
      wait_lat(n);
      check("hi_bits_zero", out_data, 10'h3FF);
      consume();
      send({{40{1'b1}}, 10'h0});
      wait_lat(n);
      check("hi_bits_ones", out_data, 10'h000);
      consume();
      for (int j = 0; j < N_OUT; j++) cfg(j, rnd(), 20 + j);
      for (int i = 0; i < 1000; i++) begin
         send(rnd());
         wait_lat(n);
         check("lat_rand", n, 5);
         consume();
      end
      for (int i = 0; i < 3; i++) v[i] = rnd();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = v[0];
      k = 0;
      pulses = 0;
      gap = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         a = in_ready && in_valid;
         #1;
         if (a) begin
            k++;
            if (k < 3) in_data = v[k];
            else in_valid = 1'b0;
         end
         if (out_valid) begin
            pulses++;
            if (pulses > 1) check("b2b_gap", gap, NCH);
            gap = 0;
         end else gap++;
      end
      check("b2b_pulses", pulses, 3);
      out_ready = 1'b0;
      xv = rnd();
      e = model(xv);
      send(xv);
      wait_lat(n);
      repeat (7) begin
         @(posedge clk);
         #1;
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, e);
         check("hold_in_ready", in_ready, 0);
      end
      consume();
      xv = rnd();
      e = model(xv);
      send(xv);
      cfg(0, ~mw[0], 0);
      cfg(3, ~mw[3], 63);
      wait_lat(n);
      check("acc_cfg_drop", out_data, e);
      consume();
      cfg(10, '1, 0);
      xv = rnd();
      e = model(xv);
      send(xv);
      wait_lat(n);
      check("addr10_drop", out_data, e);
      consume();
      send(rnd());
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midacc_out_valid", out_valid, 0);
      check("midacc_in_ready", in_ready, 1);
      repeat (8) begin
         @(posedge clk);
         #1 check("midacc_no_pulse", out_valid, 0);
      end
      send('0);
      wait_lat(n);
      check("post_rst_lat", n, 5);
      check("post_rst_zero_w", out_data, 10'h3FF);
      consume();
      send('1);
      wait_lat(n);
      check("post_rst_ones", out_data, 10'h000);
      consume();
      for (int j = 0; j < N_OUT; j++) begin
         b_cfg_we = 1'b1;
         b_cfg_addr = 4'(j);
         b_cfg_th = 6'd49;
         @(posedge clk);
         #1;
      end
      b_cfg_we = 1'b0;
      b_in_data = '0;
      b_in_valid = 1'b1;
      @(posedge clk);
      a = b_in_ready;
      #1 b_in_valid = 1'b0;
      check("c16_accept", a, 1);
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!b_out_valid && n < 20);
      check("c16_lat", n, 4);
      check("c16_data", b_out_data, 10'h3FF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
